// File: rtl/counter4_pkg.sv
// Shared types and defaults for the counter4 sequencing controller.
// Holds the controller state encoding and the drain timer sizing.
package counter4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        REPORT
    } state_t;

    localparam int CW_DEF  = 4;
    localparam int LAT_DEF = 2;

    function automatic int tmr_w(input int lat);
        return $clog2(lat + 1);
    endfunction

    localparam int LAT_TW = tmr_w(LAT_DEF);

endpackage

// File: rtl/counter4_seq_ctrl.sv
// Issues exactly N enable pulses to counter4, waits out its pipeline,
// then reports the issued count, abort flag and a count-mismatch flag.
module counter4_seq_ctrl
    import counter4_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_len,
    input  logic          hold,
    input  logic          abort,
    output logic          cnt_en,
    input  logic [CW-1:0] cnt_value,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] done_count,
    output logic          done_abort,
    output logic          done_err
);

    localparam int TW = tmr_w(LAT);

    state_t        state_q, state_d;
    logic [CW-1:0] base_q, base_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] issued_q, issued_d;
    logic          aborted_q, aborted_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] done_count_q, done_count_d;
    logic          done_abort_q, done_abort_d;
    logic          done_err_q, done_err_d;
    logic [CW-1:0] diff;
    logic          err_now;

    // Difference is taken in CW bits so counter wrap-around is harmless.
    assign diff    = cnt_value - base_q;
    assign err_now = diff != issued_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            rem_q        <= '0;
            issued_q     <= '0;
            aborted_q    <= 1'b0;
            tmr_q        <= '0;
            done_count_q <= '0;
            done_abort_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            rem_q        <= rem_d;
            issued_q     <= issued_d;
            aborted_q    <= aborted_d;
            tmr_q        <= tmr_d;
            done_count_q <= done_count_d;
            done_abort_q <= done_abort_d;
            done_err_q   <= done_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        rem_d        = rem_q;
        issued_d     = issued_q;
        aborted_d    = aborted_q;
        tmr_d        = '0;
        done_count_d = done_count_q;
        done_abort_d = done_abort_q;
        done_err_d   = done_err_q;
        cnt_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d    = cnt_value;
                    rem_d     = req_len;
                    issued_d  = '0;
                    aborted_d = 1'b0;
                    state_d   = (req_len != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                cnt_en = !hold && !abort;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (!hold) begin
                    rem_d    = rem_q - CW'(1);
                    issued_d = issued_q + CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tmr_q == TW'(LAT - 1)) begin
                    state_d      = REPORT;
                    done_count_d = issued_q;
                    done_abort_d = aborted_q;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            REPORT: begin
                done_err_d = err_now;
                state_d    = IDLE;
            end
        endcase
    end

    assign req_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign done       = state_q == REPORT;
    assign done_count = done_count_q;
    assign done_abort = done_abort_q;
    // The error flag is live in REPORT and held afterwards.
    assign done_err   = done ? err_now : done_err_q;

endmodule

// File: tb/tb_counter4_seq_ctrl.sv
// Bench for counter4_seq_ctrl with a behavioural counter4 beside it
// and a spec-level reference model compared on every cycle.
module tb_counter4_seq_ctrl;

    localparam int CW  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_len;
    logic          hold;
    logic          abort;
    logic          cnt_en;
    logic [CW-1:0] cnt_value;
    logic          busy;
    logic          done;
    logic [CW-1:0] done_count;
    logic          done_abort;
    logic          done_err;

    logic          en_p;
    logic [CW-1:0] count;
    logic [CW-1:0] off;

    int n_cmp = 0;
    int n_bad = 0;

    counter4_seq_ctrl #(.CW(CW), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_len    (req_len),
        .hold       (hold),
        .abort      (abort),
        .cnt_en     (cnt_en),
        .cnt_value  (cnt_value),
        .busy       (busy),
        .done       (done),
        .done_count (done_count),
        .done_abort (done_abort),
        .done_err   (done_err)
    );

    always #5 clk = ~clk;

    // Two-stage counter: en registered, then count advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_p  <= 1'b0;
            count <= '0;
        end else begin
            en_p <= cnt_en;
            if (en_p) count <= count + 4'd1;
        end
    end
    assign cnt_value = count + off;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 reporting.
    int            m_ph, m_left, m_iss, m_dr, m_dc;
    bit            m_ab, m_da, m_de;
    logic [CW-1:0] m_base;

    function automatic bit calc_err();
        logic [CW-1:0] d;
        d = cnt_value - m_base;
        return int'(d) != m_iss;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_left = 0; m_iss = 0; m_dr = 0; m_dc = 0;
            m_ab = 0; m_da = 0; m_de = 0; m_base = '0;
        end else begin
            case (m_ph)
                0: if (req_valid) begin
                    m_base = cnt_value;
                    m_left = int'(req_len);
                    m_iss  = 0;
                    m_ab   = 0;
                    m_dr   = 0;
                    m_ph   = (req_len != 0) ? 1 : 2;
                end
                1: if (abort) begin
                    m_ab = 1;
                    m_ph = 2;
                end else if (!hold) begin
                    m_iss++;
                    m_left--;
                    if (m_left == 0) m_ph = 2;
                end
                2: begin
                    m_dr++;
                    if (m_dr == LAT) m_ph = 3;
                end
                default: begin
                    m_dc = m_iss;
                    m_da = m_ab;
                    m_de = calc_err();
                    m_ph = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("req_ready", int'(req_ready), int'(m_ph == 0));
        chk("busy", int'(busy), int'(m_ph != 0));
        chk("done", int'(done), int'(m_ph == 3));
        chk("cnt_en", int'(cnt_en), int'(m_ph == 1 && !hold && !abort));
        chk("done_count", int'(done_count), (m_ph == 3) ? m_iss : m_dc);
        chk("done_abort", int'(done_abort), int'((m_ph == 3) ? m_ab : m_da));
        chk("done_err", int'(done_err), int'((m_ph == 3) ? calc_err() : m_de));
    end

    task automatic txn(input int len, input int hs, input int hn,
                       input int ab_k, input int hpct, input bit inj,
                       output int kd, output int dc, output int da,
                       output int de, output int cv, output int np);
        int w;
        bit got;
        w = 0; np = 0; kd = -1; dc = 0; da = 0; de = 0; cv = 0; got = 0;
        @(posedge clk); #1;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", int'(req_ready), 1);
        req_valid = 1'b1;
        req_len   = CW'(len);
        hold      = 1'b0;
        abort     = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            hold  = ((k >= hs) && (k < hs + hn)) || ($urandom_range(0, 99) < hpct);
            abort = (k == ab_k);
            if (inj && k > len) off = 4'd1;
            @(negedge clk);
            if (cnt_en) np++;
            if (done) begin
                kd  = k;
                dc  = int'(done_count);
                da  = int'(done_abort);
                de  = int'(done_err);
                cv  = int'(cnt_value);
                got = 1;
                break;
            end
        end
        hold  = 1'b0;
        abort = 1'b0;
        chk("done_seen", int'(got), 1);
        @(posedge clk); #1;
        off = '0;
        chk("ready_after", int'(req_ready), 1);
    endtask

    initial begin
        int kd, dc, da, de, cv, np, len, ab;
        rst_n = 1'b0; req_valid = 1'b0; req_len = '0;
        hold = 1'b0; abort = 1'b0; off = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(cnt_en), 0);
        rst_n = 1'b1;

        // Plain run of 5 from zero.
        txn(5, 0, 0, 0, 0, 0, kd, dc, da, de, cv, np);
        chk("t1_lat", kd, 8);
        chk("t1_pulses", np, 5);
        chk("t1_count", dc, 5);
        chk("t1_err", de, 0);
        chk("t1_cv", cv, 5);

        // Two hold cycles after the first pulse.
        txn(3, 2, 2, 0, 0, 0, kd, dc, da, de, cv, np);
        chk("t2_lat", kd, 8);
        chk("t2_pulses", np, 3);
        chk("t2_cv", cv, 8);
        chk("t2_err", de, 0);

        // Zero-length request.
        txn(0, 0, 0, 0, 0, 0, kd, dc, da, de, cv, np);
        chk("t3_lat", kd, 3);
        chk("t3_pulses", np, 0);
        chk("t3_count", dc, 0);

        // Abort with hold in the third run cycle.
        txn(10, 3, 1, 3, 0, 0, kd, dc, da, de, cv, np);
        chk("t4_lat", kd, 6);
        chk("t4_count", dc, 2);
        chk("t4_abort", da, 1);
        chk("t4_err", de, 0);
        chk("t4_cv", cv, 10);

        // Wrap from 14 by 5.
        txn(4, 0, 0, 0, 0, 0, kd, dc, da, de, cv, np);
        chk("t5a_cv", cv, 14);
        txn(5, 0, 0, 0, 0, 0, kd, dc, da, de, cv, np);
        chk("t5_cv", cv, 3);
        chk("t5_err", de, 0);
        chk("t5_abort", da, 0);

        // Reset in the middle of a run.
        @(posedge clk); #1;
        req_valid = 1'b1; req_len = 4'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mr_en", int'(cnt_en), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_ready", int'(req_ready), 1);
        chk("mr_count", int'(done_count), 0);
        chk("mr_abort", int'(done_abort), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        txn(4, 0, 0, 0, 0, 0, kd, dc, da, de, cv, np);
        chk("t6_cv", cv, 4);
        chk("t6_err", de, 0);

        // Counter offset injected while draining.
        txn(2, 0, 0, 0, 0, 1, kd, dc, da, de, cv, np);
        chk("t6_inj_err", de, 1);
        chk("t6_inj_cv", cv, 7);
        chk("t6_inj_lat", kd, 5);

        // Randomized runs against the model.
        for (int i = 0; i < 40; i++) begin
            len = $urandom_range(0, 15);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : 0;
            txn(len, 0, 0, ab, $urandom_range(0, 50), 0,
                kd, dc, da, de, cv, np);
            chk("rnd_pulses", np, dc);
            chk("rnd_err", de, 0);
            if (ab == 0) begin
                chk("rnd_count", dc, len);
                chk("rnd_abort", da, 0);
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter4_seq_ctrl.md
Name: counter4_seq_ctrl

Overview:
Sequencing controller for the 4-bit two-stage pipelined counter (counter4). It accepts "increment by N" requests over a valid/ready handshake and drives the counter's en with exactly N pulses. It waits out the counter's en-to-count_out pipeline latency, then checks that count_out advanced by the issued amount (mod 2^CW). It reports done with count, abort and error status. It sits beside counter4, is its only driver of en, and shares clk/rst_n with it.

Parameters:
CW, 4, counter width; also the width of req_len and done_count.
LAT, 2, cycles from a cnt_en=1 cycle until its effect is visible on cnt_value. Must be >= 1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request (= state IDLE)
req_len  in  CW  number of increments to issue, 0..2^CW-1
hold  in  1  pause pulse issue while high (RUN only)
abort  in  1  terminate current run (RUN only)
cnt_en  out  1  to counter en
cnt_value  in  CW  from counter count_out
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
done_count  out  CW  pulses actually issued; valid while done=1
done_abort  out  1  run ended by abort; valid while done=1
done_err  out  1  (cnt_value - base) mod 2^CW != done_count; valid while done=1

Behaviour:
- Reset (async, rst_n=0): state IDLE; cnt_en=0, busy=0, done=0, done_count=0, done_abort=0, done_err=0, req_ready=1. Reset mid-run discards the run silently, with no done. counter4 shares rst_n, so the base stays consistent.
- States: IDLE, RUN, DRAIN, REPORT. All outputs are Moore except cnt_en.
- IDLE:
  - On req_valid&req_ready: capture base=cnt_value, remaining=req_len, issued=0, aborted=0.
  - Go to RUN if req_len!=0, else DRAIN.
  - base is valid because IDLE is only entered after a full DRAIN.
- RUN, cnt_en rule: cnt_en = (state==RUN) & !hold & !abort. This is combinational, so the pulse count is exact.
- RUN, each cycle with cnt_en=1: remaining-1, issued+1. When cnt_en & remaining==1, go to DRAIN.
- RUN, abort=1: no pulse that cycle; aborted=1; go to DRAIN. Abort beats hold and beats the final pulse.
- RUN, hold=1 & !abort: no pulse; stay in RUN; no timeout.
- DRAIN: cnt_en=0. Lasts exactly LAT cycles (internal timer), then go to REPORT.
- REPORT (one cycle):
  - done=1, done_count=issued, done_abort=aborted.
  - done_err = ((cnt_value - base) mod 2^CW) != issued, evaluated in REPORT.
  - Next state: IDLE.
- Status registers done_count, done_abort and done_err hold their values after REPORT until the next REPORT. Only done pulses.
- Latency, request accepted at edge of cycle c, N>0, no hold: cnt_en high cycles c+1..c+N, DRAIN c+N+1..c+N+LAT, done at c+N+LAT+1, req_ready at c+N+LAT+2.
- Latency, N=0: done at c+LAT+1.
- Each hold cycle adds one cycle to the total.
- hold and abort are ignored outside RUN. req_valid is ignored outside IDLE.
- Wrap-around: counter wraps mod 2^CW. The difference is computed in CW bits, so base=14 with N=5 gives final count 3 and no error.
- Max N = 2^CW-1, so issued never overflows.

Decomposition:
- Package counter4_pkg holds: state enum typedef (IDLE/RUN/DRAIN/REPORT), CW and LAT defaults, and the LAT timer width localparam ($clog2(LAT+1)).
- No sub-module is natural: the drain timer and the pulse counters are inline.
- counter4 is instantiated next to this block at the parent level and in the bench.

Test Plan:
1. After reset, req_len=5, no hold (LAT=2) -> cnt_en high 5 consecutive cycles; done at c+8; done_count=5, done_err=0, done_abort=0; cnt_value=5; req_ready=1 at c+9.
2. Base 5, req_len=3, hold high for 2 cycles after the first pulse -> exactly 3 pulses, done 2 cycles later than nominal, cnt_value=8, done_err=0.
3. req_len=0 -> cnt_en never high; done at c+3; done_count=0, done_err=0.
4. req_len=10, abort in the 3rd RUN cycle together with hold -> 2 pulses issued; done_abort=1, done_count=2, done_err=0.
5. Base 14, req_len=5 -> cnt_value=3 at done, done_err=0 (wrap).
6. rst_n low mid-RUN -> all outputs at reset values immediately, no done. A following req_len=4 completes with cnt_value=4. Bench-forced cnt_value offset of +1 during DRAIN -> done_err=1.
